// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction cache sitting between the fetch stage (PCF/InstF)
// and a handshaked, possibly wait-stated instruction memory.
//   clk, rst      : rising-edge clock, asynchronous active-low reset
//   pc, fetch_en  : fetch byte address and request valid
//   flush         : invalidate every line
//   inst, stall   : combinational hit data / front-end freeze
//   mem_req/addr  : registered per-word read request, held until mem_ready
//   mem_ready/rdata: memory handshake and returned word
module inst_fetch_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t                              state;
  logic [OFFSET_BITS-1:0]              cnt, cntNext;
  logic [INDEX_BITS-1:0]               lineIdx;
  logic [TAG_BITS-1:0]                 lineTag;
  logic                                flushPend;
  logic                                memReq;
  logic [31:0]                         memAddr;
  logic [LINES-1:0]                    validArr;
  logic [TAG_BITS-1:0]                 tagArr [LINES];
  logic [LINES-1:0][WORDS-1:0][31:0]   dataArr;

  logic [OFFSET_BITS-1:0] wordSel;
  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit;
  logic [1:0]             unusedPcBits;

  assign wordSel      = pc[OFFSET_BITS+1:2];
  assign idx          = pc[TAG_LSB-1:OFFSET_BITS+2];
  assign tag          = pc[31:TAG_LSB];
  assign unusedPcBits = pc[1:0];

  // A flush in IDLE kills the lookup in the same cycle so no stale line is
  // ever returned while the valid bits are being cleared.
  assign hit   = fetch_en & validArr[idx] & (tagArr[idx] == tag) &
                 (state == IDLE) & ~flush;
  assign stall = fetch_en & ~hit;
  assign inst  = hit ? dataArr[idx][wordSel] : 32'h0;

  assign mem_req  = memReq;
  assign mem_addr = memAddr;
  assign cntNext  = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lineIdx   <= '0;
      lineTag   <= '0;
      flushPend <= 1'b0;
      memReq    <= 1'b0;
      memAddr   <= '0;
      validArr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) validArr <= '0;
          if (fetch_en && !hit) begin
            lineIdx <= idx;
            lineTag <= tag;
            cnt     <= '0;
            memReq  <= 1'b1;
            memAddr <= {pc[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
            state   <= REFILL;
          end
        end
        REFILL: begin
          if (flush) flushPend <= 1'b1;
          if (mem_ready) begin
            cnt <= cntNext;
            if (cnt == OFFSET_BITS'(WORDS-1)) begin
              memReq  <= 1'b0;
              memAddr <= '0;
              state   <= DONE;
            end else begin
              memAddr <= {lineTag, lineIdx, cntNext, 2'b00};
            end
          end
        end
        DONE: begin
          // A flush seen during the burst also wipes the line just filled.
          if (flushPend || flush) validArr <= '0;
          else                    validArr[lineIdx] <= 1'b1;
          flushPend <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays need no reset: valid gates every read.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) dataArr[lineIdx][cnt] <= mem_rdata;
    if (state == DONE)                tagArr[lineIdx]       <= lineTag;
  end
endmodule

// File: tb/tb_inst_fetch_cache.sv
module tb_inst_fetch_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [31:0] inst;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int nChecks = 0;
  int nFail   = 0;
  logic waitMode = 1'b0;
  int   wcnt = 0;

  inst_fetch_cache #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .inst(inst), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory model: zero-wait, or ready on every 3rd cycle of a request.
  assign mem_rdata = memWord(mem_addr);
  assign mem_ready = waitMode ? (wcnt == 2) : 1'b1;
  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] p, input logic fe, input logic fl);
    @(negedge clk);
    pc = p; fetch_en = fe; flush = fl;
    #1;
  endtask

  // Fetch p until it hits; checks stall count, burst start address,
  // address hold across wait states, +4 stepping after each ready, hit data.
  task automatic fetchUntilHit(input string name, input logic [31:0] p, input int expStalls);
    int   n = 0;
    logic done = 1'b0;
    logic prevReq = 1'b0, prevRdy = 1'b0, seenReq = 1'b0;
    logic [31:0] prevAddr = '0;
    for (int i = 0; i < 100 && !done; i++) begin
      step(p, 1'b1, 1'b0);
      if (!stall) begin
        done = 1'b1;
      end else begin
        n++;
        if (mem_req && !seenReq) begin
          seenReq = 1'b1;
          chk({name, " burst start"}, mem_addr, {p[31:4], 4'h0});
        end
        if (prevReq && !prevRdy) begin
          chk({name, " req hold"}, {31'h0, mem_req}, 32'h1);
          chk({name, " addr hold"}, mem_addr, prevAddr);
        end else if (prevReq && prevRdy && mem_req) begin
          chk({name, " addr step"}, mem_addr, prevAddr + 32'h4);
        end
        prevReq = mem_req; prevRdy = mem_ready; prevAddr = mem_addr;
      end
    end
    if (!done) begin
      nChecks++; nFail++;
      $display("FAIL %s: no hit within 100 cycles", name);
    end else begin
      chk({name, " stall cycles"}, n, expStalls);
      chk({name, " hit inst"}, inst, memWord({p[31:2], 2'b00}));
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        fe;
    logic        expStall;
    logic [31:0] expInst;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // Cold miss at 0xBFC00000, zero-wait memory, cycle by cycle.
    tbl[0] = '{32'hBFC00000, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{32'hBFC00000, 1'b1, 1'b1, 32'h0, 1'b1, 32'hBFC00000};
    tbl[2] = '{32'hBFC00000, 1'b1, 1'b1, 32'h0, 1'b1, 32'hBFC00004};
    tbl[3] = '{32'hBFC00000, 1'b1, 1'b1, 32'h0, 1'b1, 32'hBFC00008};
    tbl[4] = '{32'hBFC00000, 1'b1, 1'b1, 32'h0, 1'b1, 32'hBFC0000C};
    tbl[5] = '{32'hBFC00000, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[6] = '{32'hBFC00000, 1'b1, 1'b0, memWord(32'hBFC00000), 1'b0, 32'h0};
    tbl[7] = '{32'hBFC00008, 1'b1, 1'b0, memWord(32'hBFC00008), 1'b0, 32'h0};
    tbl[8] = '{32'hBFC00008, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};

    rst = 1'b0; pc = 32'hBFC00000; fetch_en = 1'b1; flush = 1'b0;
    #12;
    chk("reset stall", {31'h0, stall}, 32'h1);
    chk("reset inst", inst, 32'h0);
    chk("reset mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    fetch_en = 1'b0;
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].pc, tbl[i].fe, 1'b0);
      chk($sformatf("cold[%0d] stall", i), {31'h0, stall}, {31'h0, tbl[i].expStall});
      chk($sformatf("cold[%0d] inst", i), inst, tbl[i].expInst);
      chk($sformatf("cold[%0d] mem_req", i), {31'h0, mem_req}, {31'h0, tbl[i].expReq});
      chk($sformatf("cold[%0d] mem_addr", i), mem_addr, tbl[i].expAddr);
    end

    // Wait states: 1 + 4*3 + 1.
    waitMode = 1'b1;
    fetchUntilHit("waitstate", 32'h00001004, 14);
    waitMode = 1'b0;

    // Conflict eviction on index 4.
    fetchUntilHit("conflict fill", 32'h00000040, 6);
    fetchUntilHit("conflict evict", 32'h00000440, 6);
    fetchUntilHit("conflict refetch", 32'h00000040, 6);

    // Flush during the 2nd word of a refill.
    step(32'h00002000, 1'b1, 1'b0);
    chk("flush c0 stall", {31'h0, stall}, 32'h1);
    step(32'h00002000, 1'b1, 1'b0);
    chk("flush c1 addr", mem_addr, 32'h00002000);
    step(32'h00002000, 1'b1, 1'b1);
    chk("flush c2 addr", mem_addr, 32'h00002004);
    step(32'h00002000, 1'b1, 1'b0);
    step(32'h00002000, 1'b1, 1'b0);
    step(32'h00002000, 1'b1, 1'b0);
    chk("flush done stall", {31'h0, stall}, 32'h1);
    fetchUntilHit("flush refilled line", 32'h00002000, 6);
    fetchUntilHit("flush other line", 32'h00000040, 6);

    // pc moves 0x100 -> 0x200 mid-burst.
    step(32'h00000100, 1'b1, 1'b0);
    step(32'h00000100, 1'b1, 1'b0);
    chk("pcchg addr0", mem_addr, 32'h00000100);
    step(32'h00000200, 1'b1, 1'b0);
    chk("pcchg addr1", mem_addr, 32'h00000104);
    chk("pcchg stall", {31'h0, stall}, 32'h1);
    step(32'h00000200, 1'b1, 1'b0);
    step(32'h00000200, 1'b1, 1'b0);
    chk("pcchg addr3", mem_addr, 32'h0000010C);
    step(32'h00000200, 1'b1, 1'b0);
    chk("pcchg done stall", {31'h0, stall}, 32'h1);
    fetchUntilHit("pcchg new pc", 32'h00000200, 6);
    fetchUntilHit("pcchg old line", 32'h0000010C, 0);

    // Reset after two words of a refill.
    step(32'h00003000, 1'b1, 1'b0);
    step(32'h00003000, 1'b1, 1'b0);
    step(32'h00003000, 1'b1, 1'b0);
    chk("rstmid addr1", mem_addr, 32'h00003004);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstmid mem_req", {31'h0, mem_req}, 32'h0);
    chk("rstmid mem_addr", mem_addr, 32'h0);
    chk("rstmid stall", {31'h0, stall}, 32'h1);
    chk("rstmid inst", inst, 32'h0);
    fetch_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    fetchUntilHit("rstmid refetch", 32'h00003008, 6);
    fetchUntilHit("rstmid old line", 32'h00000100, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
